// File: rtl/mem_port_arbiter.sv
// Arbitrates LDQ loads and SDQ store commits onto a single D-cache port and
// tracks outstanding loads so in-order responses are routed back to the LDQ.
module mem_port_arbiter #(
   parameter int unsigned LDQ_ENTRIES  = 16,
   parameter int unsigned SDQ_ENTRIES  = 8,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned HIGH_WATER   = SDQ_ENTRIES - 2,
   parameter int unsigned LOW_WATER    = 2,
   parameter int unsigned OUTST_DEPTH  = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             ld_vld,
   input  logic [$clog2(LDQ_ENTRIES)-1:0]   ld_ldq_idx,
   input  logic [31:0]                      ld_addr,
   output logic                             ld_rdy,
   input  logic                             st_vld,
   input  logic [31:0]                      st_addr,
   input  logic [31:0]                      st_data,
   output logic                             st_rdy,
   input  logic [$clog2(SDQ_ENTRIES):0]     sdq_count,
   input  logic                             flush,
   output logic                             dc_req_vld,
   output logic                             dc_req_we,
   output logic [31:0]                      dc_req_addr,
   output logic [31:0]                      dc_req_wdata,
   input  logic                             dc_req_rdy,
   input  logic                             dc_resp_vld,
   input  logic [31:0]                      dc_resp_data,
   output logic                             ld_resp_vld,
   output logic [$clog2(LDQ_ENTRIES)-1:0]   ld_resp_ldq_idx,
   output logic [31:0]                      ld_resp_data
);

   localparam int unsigned LIDX_W = $clog2(LDQ_ENTRIES);
   localparam int unsigned SDQ_CW = $clog2(SDQ_ENTRIES) + 1;
   localparam int unsigned PTR_W  = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(OUTST_DEPTH + 1);
   localparam int unsigned ST_W   = $clog2(STARVE_LIMIT + 1);

   localparam logic [SDQ_CW-1:0] LP_HIGH   = SDQ_CW'(HIGH_WATER);
   localparam logic [SDQ_CW-1:0] LP_LOW    = SDQ_CW'(LOW_WATER);
   localparam logic [CNT_W-1:0]  LP_DEPTH  = CNT_W'(OUTST_DEPTH);
   localparam logic [PTR_W-1:0]  LP_LAST   = PTR_W'(OUTST_DEPTH - 1);
   localparam logic [ST_W-1:0]   LP_STARVE = ST_W'(STARVE_LIMIT);

   typedef enum logic {
      LOAD_PRI,
      STORE_DRAIN
   } mode_t;

   mode_t              r_mode;
   mode_t              w_mode_nxt;
   logic [ST_W-1:0]    r_starve;
   logic               w_ld_elig;
   logic               w_ld_gnt;
   logic               w_st_gnt;
   logic               w_push;
   logic               w_pop;

   logic [LIDX_W-1:0]      r_idx [OUTST_DEPTH];
   logic [OUTST_DEPTH-1:0] r_killed;
   logic [PTR_W-1:0]       r_wr;
   logic [PTR_W-1:0]       r_rd;
   logic [CNT_W-1:0]       r_count;

   function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
      return (p == LP_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Mode FSM: state register
   always_ff @(posedge clk) begin
      if (rst) r_mode <= LOAD_PRI;
      else     r_mode <= w_mode_nxt;
   end

   // Mode FSM: next state
   always_comb begin
      w_mode_nxt = r_mode;
      case (r_mode)
         LOAD_PRI:    if (sdq_count >= LP_HIGH || r_starve == LP_STARVE) w_mode_nxt = STORE_DRAIN;
         STORE_DRAIN: if (!st_vld || sdq_count <= LP_LOW)                 w_mode_nxt = LOAD_PRI;
         default:     w_mode_nxt = LOAD_PRI;
      endcase
   end

   assign w_ld_elig = ld_vld && (r_count < LP_DEPTH) && !flush;

   // Mode FSM: grant outputs
   always_comb begin
      w_ld_gnt = 1'b0;
      w_st_gnt = 1'b0;
      if (!rst) begin
         case (r_mode)
            LOAD_PRI: begin
               if (w_ld_elig)   w_ld_gnt = 1'b1;
               else if (st_vld) w_st_gnt = 1'b1;
            end
            STORE_DRAIN: begin
               if (st_vld)         w_st_gnt = 1'b1;
               else if (w_ld_elig) w_ld_gnt = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign dc_req_vld   = w_ld_gnt | w_st_gnt;
   assign dc_req_we    = w_st_gnt;
   assign dc_req_addr  = w_st_gnt ? st_addr : (w_ld_gnt ? ld_addr : '0);
   assign dc_req_wdata = w_st_gnt ? st_data : '0;
   assign ld_rdy       = w_ld_gnt && dc_req_rdy;
   assign st_rdy       = w_st_gnt && dc_req_rdy;

   always_ff @(posedge clk) begin
      if (rst)                   r_starve <= '0;
      else if (!st_vld || st_rdy) r_starve <= '0;
      else if (r_starve != LP_STARVE) r_starve <= r_starve + ST_W'(1);
   end

   assign w_push = ld_rdy;
   assign w_pop  = dc_resp_vld && (r_count != '0);

   always_ff @(posedge clk) begin
      if (w_push) r_idx[r_wr] <= ld_ldq_idx;
   end

   // Flush marks every slot killed; empty slots are harmless since a push
   // (never in a flush cycle) rewrites its killed bit to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_killed <= '0;
         r_wr     <= '0;
         r_rd     <= '0;
         r_count  <= '0;
      end else begin
         if (flush) r_killed <= '1;
         if (w_push) begin
            r_killed[r_wr] <= 1'b0;
            r_wr           <= f_inc(r_wr);
         end
         if (w_pop) r_rd <= f_inc(r_rd);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign ld_resp_vld     = w_pop && !r_killed[r_rd] && !flush && !rst;
   assign ld_resp_ldq_idx = r_idx[r_rd];
   assign ld_resp_data    = dc_resp_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: stimulus queues expected
// per-cycle strobes, D-cache requests and LDQ writebacks; a monitor compares.
module tb_mem_port_arbiter;

   logic        clk = 1'b1;
   logic        rst;
   logic        ld_vld;
   logic [3:0]  ld_ldq_idx;
   logic [31:0] ld_addr;
   logic        ld_rdy;
   logic        st_vld;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_rdy;
   logic [3:0]  sdq_count;
   logic        flush;
   logic        dc_req_vld;
   logic        dc_req_we;
   logic [31:0] dc_req_addr;
   logic [31:0] dc_req_wdata;
   logic        dc_req_rdy;
   logic        dc_resp_vld;
   logic [31:0] dc_resp_data;
   logic        ld_resp_vld;
   logic [3:0]  ld_resp_ldq_idx;
   logic [31:0] ld_resp_data;

   mem_port_arbiter #(
      .LDQ_ENTRIES (16),
      .SDQ_ENTRIES (8),
      .STARVE_LIMIT(4),
      .LOW_WATER   (2),
      .OUTST_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ld_vld         (ld_vld),
      .ld_ldq_idx     (ld_ldq_idx),
      .ld_addr        (ld_addr),
      .ld_rdy         (ld_rdy),
      .st_vld         (st_vld),
      .st_addr        (st_addr),
      .st_data        (st_data),
      .st_rdy         (st_rdy),
      .sdq_count      (sdq_count),
      .flush          (flush),
      .dc_req_vld     (dc_req_vld),
      .dc_req_we      (dc_req_we),
      .dc_req_addr    (dc_req_addr),
      .dc_req_wdata   (dc_req_wdata),
      .dc_req_rdy     (dc_req_rdy),
      .dc_resp_vld    (dc_resp_vld),
      .dc_resp_data   (dc_resp_data),
      .ld_resp_vld    (ld_resp_vld),
      .ld_resp_ldq_idx(ld_resp_ldq_idx),
      .ld_resp_data   (ld_resp_data)
   );

   always #5 clk = ~clk;

   typedef struct packed { bit lr; bit sr; bit rv; bit we; bit rsp; } flags_t;
   typedef struct packed { bit we; logic [31:0] addr; logic [31:0] wdata; } req_t;
   typedef struct packed { logic [3:0] idx; logic [31:0] data; } rsp_t;

   flags_t q_flags [$];
   req_t   q_req [$];
   rsp_t   q_rsp [$];
   int     n_checks = 0;
   int     n_errors = 0;
   bit     done = 1'b0;
   bit     end_checked = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      flags_t f;
      req_t   r;
      rsp_t   p;
      if (q_flags.size() > 0) begin
         f = q_flags.pop_front();
         chk("ld_rdy",      32'(ld_rdy),      32'(f.lr));
         chk("st_rdy",      32'(st_rdy),      32'(f.sr));
         chk("dc_req_vld",  32'(dc_req_vld),  32'(f.rv));
         chk("ld_resp_vld", 32'(ld_resp_vld), 32'(f.rsp));
         if (f.rv) chk("dc_req_we", 32'(dc_req_we), 32'(f.we));
      end
      if (dc_req_vld && dc_req_rdy) begin
         if (q_req.size() == 0) begin
            chk("unexpected_req", 32'(1), 32'(0));
         end else begin
            r = q_req.pop_front();
            chk("req_we",    32'(dc_req_we), 32'(r.we));
            chk("req_addr",  dc_req_addr,    r.addr);
            chk("req_wdata", dc_req_wdata,   r.wdata);
         end
      end
      if (ld_resp_vld) begin
         if (q_rsp.size() == 0) begin
            chk("unexpected_resp", 32'(1), 32'(0));
         end else begin
            p = q_rsp.pop_front();
            chk("resp_idx",  32'(ld_resp_ldq_idx), 32'(p.idx));
            chk("resp_data", ld_resp_data,         p.data);
         end
      end
      if (done && !end_checked) begin
         end_checked = 1'b1;
         chk("req_left",  32'(q_req.size()), 32'(0));
         chk("resp_left", 32'(q_rsp.size()), 32'(0));
      end
   end

   task automatic step(input bit lr, input bit sr, input bit rv, input bit we, input bit rsp);
      flags_t f;
      f = '{lr: lr, sr: sr, rv: rv, we: we, rsp: rsp};
      q_flags.push_back(f);
      @(posedge clk);
      #1;
   endtask

   task automatic set_ld(input bit v, input logic [3:0] idx, input logic [31:0] a);
      ld_vld = v; ld_ldq_idx = idx; ld_addr = a;
   endtask

   task automatic set_st(input bit v, input logic [31:0] a, input logic [31:0] d);
      st_vld = v; st_addr = a; st_data = d;
   endtask

   task automatic resp(input bit v, input logic [31:0] d);
      dc_resp_vld = v; dc_resp_data = d;
   endtask

   task automatic exp_req(input bit we, input logic [31:0] a, input logic [31:0] d);
      req_t r;
      r = '{we: we, addr: a, wdata: d};
      q_req.push_back(r);
   endtask

   task automatic exp_rsp(input logic [3:0] idx, input logic [31:0] d);
      rsp_t p;
      p = '{idx: idx, data: d};
      q_rsp.push_back(p);
   endtask

   initial begin
      // reset with every request input active
      rst = 1'b1; flush = 1'b0; sdq_count = 4'd3; dc_req_rdy = 1'b1;
      set_ld(1'b1, 4'd0, 32'h1); set_st(1'b1, 32'h2, 32'h3); resp(1'b1, 32'h4);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      rst = 1'b0; set_ld(1'b0, 4'd0, 32'h0); set_st(1'b0, 32'h0, 32'h0); resp(1'b0, 32'h0);
      step(0, 0, 0, 0, 0);

      // single load and its response
      set_ld(1'b1, 4'd15, 32'd5108); exp_req(1'b0, 32'd5108, 32'h0);
      step(1, 0, 1, 0, 0);
      set_ld(1'b0, 4'd0, 32'h0); resp(1'b1, 32'hABCD); exp_rsp(4'd15, 32'hABCD);
      step(0, 0, 0, 0, 1);
      resp(1'b0, 32'h0);

      // high water drives drain mode, low water returns to load priority
      sdq_count = 4'd6; dc_req_rdy = 1'b0;
      set_ld(1'b1, 4'd3, 32'h100); set_st(1'b1, 32'h200, 32'h55);
      step(0, 0, 1, 0, 0);
      dc_req_rdy = 1'b1; exp_req(1'b1, 32'h200, 32'h55);
      step(0, 1, 1, 1, 0);
      sdq_count = 4'd2; dc_req_rdy = 1'b0;
      step(0, 0, 1, 1, 0);
      dc_req_rdy = 1'b1; exp_req(1'b0, 32'h100, 32'h0);
      step(1, 0, 1, 0, 0);
      set_ld(1'b0, 4'd0, 32'h0); set_st(1'b0, 32'h0, 32'h0);
      resp(1'b1, 32'h1111); exp_rsp(4'd3, 32'h1111);
      step(0, 0, 0, 0, 1);
      resp(1'b0, 32'h0); sdq_count = 4'd3;

      // outstanding limit: third load waits until the cycle after a pop
      set_ld(1'b1, 4'd1, 32'h10); exp_req(1'b0, 32'h10, 32'h0);
      step(1, 0, 1, 0, 0);
      set_ld(1'b1, 4'd2, 32'h20); exp_req(1'b0, 32'h20, 32'h0);
      step(1, 0, 1, 0, 0);
      set_ld(1'b1, 4'd3, 32'h30);
      step(0, 0, 0, 0, 0);
      resp(1'b1, 32'hA1); exp_rsp(4'd1, 32'hA1);
      step(0, 0, 0, 0, 1);
      resp(1'b0, 32'h0); exp_req(1'b0, 32'h30, 32'h0);
      step(1, 0, 1, 0, 0);
      set_ld(1'b0, 4'd0, 32'h0); resp(1'b1, 32'hA2); exp_rsp(4'd2, 32'hA2);
      step(0, 0, 0, 0, 1);
      resp(1'b1, 32'hA3); exp_rsp(4'd3, 32'hA3);
      step(0, 0, 0, 0, 1);
      resp(1'b0, 32'h0);

      // flush kills two outstanding loads
      set_ld(1'b1, 4'd4, 32'h40); exp_req(1'b0, 32'h40, 32'h0);
      step(1, 0, 1, 0, 0);
      set_ld(1'b1, 4'd5, 32'h50); exp_req(1'b0, 32'h50, 32'h0);
      step(1, 0, 1, 0, 0);
      set_ld(1'b1, 4'd6, 32'h60); flush = 1'b1;
      step(0, 0, 0, 0, 0);
      flush = 1'b0; set_ld(1'b0, 4'd0, 32'h0); resp(1'b1, 32'hB1);
      step(0, 0, 0, 0, 0);
      resp(1'b1, 32'hB2);
      step(0, 0, 0, 0, 0);
      resp(1'b0, 32'h0); set_ld(1'b1, 4'd7, 32'h70); exp_req(1'b0, 32'h70, 32'h0);
      step(1, 0, 1, 0, 0);
      set_ld(1'b0, 4'd0, 32'h0); resp(1'b1, 32'hB7); exp_rsp(4'd7, 32'hB7);
      step(0, 0, 0, 0, 1);

      // flush cycle: response suppressed, load blocked, store still served
      resp(1'b0, 32'h0); set_ld(1'b1, 4'd8, 32'h80); exp_req(1'b0, 32'h80, 32'h0);
      step(1, 0, 1, 0, 0);
      set_ld(1'b1, 4'd9, 32'h90); flush = 1'b1; resp(1'b1, 32'hB8);
      set_st(1'b1, 32'h210, 32'h66); exp_req(1'b1, 32'h210, 32'h66);
      step(0, 1, 1, 1, 0);
      flush = 1'b0; set_ld(1'b0, 4'd0, 32'h0); set_st(1'b0, 32'h0, 32'h0);
      resp(1'b1, 32'hEE);
      step(0, 0, 0, 0, 0);
      resp(1'b0, 32'h0);

      // starvation: loads win until starve count saturates, then store
      set_st(1'b1, 32'h300, 32'h77);
      set_ld(1'b1, 4'd0, 32'h400); exp_req(1'b0, 32'h400, 32'h0);
      step(1, 0, 1, 0, 0);
      for (int n = 1; n <= 4; n++) begin
         set_ld(1'b1, 4'(n), 32'h400 + 32'(n)); exp_req(1'b0, 32'h400 + 32'(n), 32'h0);
         resp(1'b1, 32'hC0 + 32'(n - 1)); exp_rsp(4'(n - 1), 32'hC0 + 32'(n - 1));
         step(1, 0, 1, 0, 1);
      end
      set_ld(1'b1, 4'd5, 32'h405); resp(1'b1, 32'hC4); exp_rsp(4'd4, 32'hC4);
      exp_req(1'b1, 32'h300, 32'h77);
      step(0, 1, 1, 1, 1);
      set_ld(1'b0, 4'd0, 32'h0); set_st(1'b0, 32'h0, 32'h0); resp(1'b0, 32'h0);
      step(0, 0, 0, 0, 0);

      // reset mid-operation discards the outstanding load
      set_ld(1'b1, 4'd9, 32'h900); exp_req(1'b0, 32'h900, 32'h0);
      step(1, 0, 1, 0, 0);
      rst = 1'b1; set_ld(1'b1, 4'd10, 32'hA00); set_st(1'b1, 32'h310, 32'h88);
      sdq_count = 4'd6; resp(1'b1, 32'hD1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      rst = 1'b0; set_ld(1'b0, 4'd0, 32'h0); set_st(1'b0, 32'h0, 32'h0);
      sdq_count = 4'd3; resp(1'b1, 32'hD2);
      step(0, 0, 0, 0, 0);
      resp(1'b0, 32'h0); set_ld(1'b1, 4'd11, 32'hB00); set_st(1'b1, 32'h320, 32'h99);
      exp_req(1'b0, 32'hB00, 32'h0);
      step(1, 0, 1, 0, 0);
      set_ld(1'b0, 4'd0, 32'h0); exp_req(1'b1, 32'h320, 32'h99);
      resp(1'b1, 32'hD3); exp_rsp(4'd11, 32'hD3);
      step(0, 1, 1, 1, 1);
      set_st(1'b0, 32'h0, 32'h0); resp(1'b0, 32'h0);
      step(0, 0, 0, 0, 0);

      done = 1'b1;
      @(negedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
